// File: rtl/traffic_light_fsm.sv
// Single-approach traffic-light controller: GREEN -> YELLOW -> RED with a sticky
// pedestrian request that can shorten GREEN and a level-sensitive emergency override.
module traffic_light_fsm #(
  parameter int unsigned GREEN_TIME  = 10,
  parameter int unsigned MIN_GREEN   = 3,
  parameter int unsigned YELLOW_TIME = 3,
  parameter int unsigned RED_TIME    = 6,
  parameter int unsigned TIMER_W     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ped_btn,
  input  logic emergency,
  output logic red,
  output logic yellow,
  output logic green,
  output logic walk,
  output logic dont_walk
);

  typedef enum logic [1:0] {SGreen, SYellow, SRed, SEmerg} state_e;

  localparam logic [TIMER_W-1:0] GreenLast  = TIMER_W'(GREEN_TIME - 1);
  localparam logic [TIMER_W-1:0] MinLast    = TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] YellowLast = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] RedLast    = TIMER_W'(RED_TIME - 1);

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 ped_req_q, ped_req_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SGreen;
      timer_q   <= '0;
      ped_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ped_req_q <= ped_req_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ped_req_d = ped_req_q;
    if (emergency) begin
      state_d = SEmerg;
    end else begin
      unique case (state_q)
        SGreen: begin
          if (timer_q == GreenLast || (ped_req_q && timer_q >= MinLast)) state_d = SYellow;
        end
        SYellow: if (timer_q == YellowLast) state_d = SRed;
        SRed:    if (timer_q == RedLast) state_d = SGreen;
        SEmerg:  state_d = SRed;
        default: state_d = SGreen;
      endcase
    end

    timer_d = (state_d != state_q) ? '0 : timer_q + 1'b1;

    // Only GREEN/YELLOW accept requests; RED entry serves them and EMERG discards them.
    if (ped_btn && (state_q == SGreen || state_q == SYellow)) ped_req_d = 1'b1;
    if (state_d == SEmerg || (state_d == SRed && state_q != SRed)) ped_req_d = 1'b0;
  end

  always_comb begin
    red    = 1'b0;
    yellow = 1'b0;
    green  = 1'b0;
    walk   = 1'b0;
    unique case (state_q)
      SGreen:  green  = 1'b1;
      SYellow: yellow = 1'b1;
      SRed: begin
        red  = 1'b1;
        walk = 1'b1;
      end
      SEmerg:  red    = 1'b1;
      default: green  = 1'b1;
    endcase
    dont_walk = ~walk;
  end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Scoreboarded bench for traffic_light_fsm: a phase-length reference model predicts the
// lamps after every edge; a monitor compares them one step after each rising edge.
module tb_traffic_light_fsm;

  localparam int GT = 10;
  localparam int MG = 3;
  localparam int YT = 3;
  localparam int RT = 6;

  localparam int PG = 0;
  localparam int PY = 1;
  localparam int PR = 2;
  localparam int PE = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ped_btn = 1'b0;
  logic emergency = 1'b0;
  logic red, yellow, green, walk, dont_walk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] exp_q[$];

  // Model: current phase, cycles spent in it, and the length GREEN will run for.
  int m_phase = PG;
  int m_age   = 0;
  int m_len   = GT;

  traffic_light_fsm #(
    .GREEN_TIME (GT),
    .MIN_GREEN  (MG),
    .YELLOW_TIME(YT),
    .RED_TIME   (RT),
    .TIMER_W    (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ped_btn  (ped_btn),
    .emergency(emergency),
    .red      (red),
    .yellow   (yellow),
    .green    (green),
    .walk     (walk),
    .dont_walk(dont_walk)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] lamps(input int p);
    case (p)
      PG:      return 5'b00101;
      PY:      return 5'b01001;
      PR:      return 5'b10010;
      default: return 5'b10001;
    endcase
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_phase = PG;
    m_age   = 0;
    m_len   = GT;
  endtask

  task automatic enter(input int p);
    m_phase = p;
    m_age   = 0;
    if (p == PG) m_len = GT;
  endtask

  // A request seen at GREEN age k ends GREEN after max(k+2, MIN_GREEN) cycles, capped at GT.
  task automatic model_edge(input logic ped, input logic emg);
    if (emg) begin
      enter(PE);
    end else begin
      case (m_phase)
        PG: begin
          if (m_age + 1 == m_len) enter(PY);
          else begin
            if (ped) m_len = imin(m_len, imax(m_age + 2, MG));
            m_age++;
          end
        end
        PY: if (m_age + 1 == YT) enter(PR); else m_age++;
        PR: if (m_age + 1 == RT) enter(PG); else m_age++;
        default: enter(PR);
      endcase
    end
  endtask

  // Called at a falling edge: drive inputs for the coming edge and queue its result.
  task automatic step(input logic ped, input logic emg);
    ped_btn   = ped;
    emergency = emg;
    model_edge(ped, emg);
    exp_q.push_back(lamps(m_phase));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic run_until(input int p, input int age);
    int guard;
    guard = 0;
    while (!(m_phase == p && m_age == age) && guard < 100) begin
      step(1'b0, 1'b0);
      guard++;
    end
    n_tests++;
    if (guard >= 100) begin
      n_fail++;
      $display("FAIL run_until: phase %0d age %0d never reached, required phase %0d age %0d",
               m_phase, m_age, p, age);
    end
  endtask

  task automatic check_now(input string name, input logic [4:0] req);
    logic [4:0] got;
    got = {red, yellow, green, walk, dont_walk};
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got rygwd=%b required %b", name, got, req);
    end
  endtask

  // Assert reset between edges and confirm the outputs change without a clock.
  task automatic async_reset(input string name);
    #2 reset = 1'b0;
    #1 check_now(name, lamps(PG));
    model_reset();
    ped_btn   = 1'b0;
    emergency = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_now({name, "_held"}, lamps(PG));
    reset = 1'b1;
  endtask

  initial begin : monitor
    logic [4:0] e;
    logic [4:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {red, yellow, green, walk, dont_walk};
        n_tests++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL lamps @%0t: got rygwd=%b required %b", $time, got, e);
        end
      end
    end
  end

  initial begin : stimulus
    int emg_left;
    #1 check_now("reset_initial", lamps(PG));
    @(negedge clk);
    @(negedge clk);
    check_now("reset_held", lamps(PG));
    reset = 1'b1;

    // Free-running cycle, twice round plus a little.
    idle(2 * (GT + YT + RT) + 2);

    // Early pedestrian request at GREEN cycle 0, then a late one at cycle 7.
    run_until(PG, 0);
    step(1'b1, 1'b0);
    idle(12);
    run_until(PG, 7);
    step(1'b1, 1'b0);
    idle(15);

    // Request during RED is ignored; next GREEN runs full length.
    run_until(PR, 2);
    step(1'b1, 1'b0);
    idle(20);

    // Two-cycle emergency mid-GREEN.
    run_until(PG, 4);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    idle(20);

    // Emergency and request together during YELLOW: request must be dropped.
    run_until(PY, 1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    idle(25);

    // Asynchronous reset mid-YELLOW and mid-EMERG.
    run_until(PY, 1);
    async_reset("reset_mid_yellow");
    idle(12);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    async_reset("reset_mid_emerg");
    idle(12);

    // Randomized traffic with occasional emergency bursts.
    emg_left = 0;
    for (int i = 0; i < 800; i++) begin
      if (emg_left == 0 && $urandom_range(0, 40) == 0) emg_left = $urandom_range(1, 4);
      step(($urandom_range(0, 4) == 0), (emg_left > 0));
      if (emg_left > 0) emg_left--;
    end
    idle(2);

    @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
